// File: rtl/fc_stage.sv
// fc_stage: fully-connected classifier stage fed by the pooled pixel stream.
// Each accepted sample is multiply-accumulated into N_OUT neuron accumulators;
// after N_IN samples the accumulators are scaled, biased, activated and
// saturated, then the N_OUT results are streamed out one per enabled cycle.
module fc_stage #(
   parameter int dataWidth = 8,
   parameter int N_IN      = 169,
   parameter int N_OUT     = 10,
   parameter int FRAC      = 4,
   parameter int actype    = 1,
   localparam int IW       = (N_IN  > 1) ? $clog2(N_IN)  : 1,
   localparam int KW       = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
   input  logic                       clk,
   input  logic                       global_rst,
   input  logic                       ce,
   input  logic [dataWidth-1:0]       data_in,
   input  logic                       valid_in,
   input  logic                       end_in,
   input  logic [N_OUT*dataWidth-1:0] weight_in,
   input  logic [N_OUT*dataWidth-1:0] bias_in,
   output logic [IW-1:0]              in_idx,
   output logic                       busy,
   output logic [dataWidth-1:0]       data_out,
   output logic [KW-1:0]              class_idx,
   output logic                       valid_out,
   output logic                       end_out,
   output logic                       overrun
);

   localparam int ACCW = 2*dataWidth + $clog2(N_IN);
   localparam int PW   = 2*dataWidth;

   localparam logic signed [ACCW:0] SAT_MAX = {{(ACCW+2-dataWidth){1'b0}}, {(dataWidth-1){1'b1}}};
   localparam logic signed [ACCW:0] SAT_MIN = {{(ACCW+2-dataWidth){1'b1}}, {(dataWidth-1){1'b0}}};

   typedef enum logic [1:0] {ACCUM, FINAL, DRAIN} StateType;

   StateType r_state;
   StateType w_stateNext;

   logic signed [ACCW-1:0]      r_acc   [N_OUT];
   logic        [dataWidth-1:0] r_res   [N_OUT];
   logic        [IW-1:0]        r_inIdx;
   logic        [KW-1:0]        r_k;
   logic        [dataWidth-1:0] r_dataOut;
   logic        [KW-1:0]        r_classIdx;
   logic                        r_validOut;
   logic                        r_endOut;
   logic                        r_overrun;

   logic                        w_sample;
   logic                        w_accept;
   logic                        w_lastIn;
   logic                        w_lastOut;
   logic signed [PW-1:0]        w_dataExt;
   logic signed [PW-1:0]        w_weightExt [N_OUT];
   logic signed [PW-1:0]        w_prod      [N_OUT];
   logic signed [ACCW-1:0]      w_prodExt   [N_OUT];
   logic signed [ACCW-1:0]      w_shift     [N_OUT];
   logic signed [ACCW:0]        w_sum       [N_OUT];
   logic        [dataWidth-1:0] w_res       [N_OUT];

   assign w_sample  = valid_in & ~end_in;
   assign w_accept  = ce & w_sample & (r_state == ACCUM);
   assign w_lastIn  = (r_inIdx == IW'(N_IN-1));
   assign w_lastOut = (r_k == KW'(N_OUT-1));

   assign in_idx    = r_inIdx;
   assign busy      = (r_state != ACCUM);
   assign data_out  = r_dataOut;
   assign class_idx = r_classIdx;
   assign valid_out = r_validOut;
   assign end_out   = r_endOut;
   assign overrun   = r_overrun;

   // Per-neuron product of the incoming sample, and the scaled/biased/activated/saturated result of each accumulator
   always_comb begin
      w_dataExt = {{dataWidth{data_in[dataWidth-1]}}, data_in};
      for (int j = 0; j < N_OUT; j++) begin
         w_weightExt[j] = {{dataWidth{weight_in[j*dataWidth+dataWidth-1]}}, weight_in[j*dataWidth +: dataWidth]};
         w_prod[j]      = w_dataExt * w_weightExt[j];
         w_prodExt[j]   = {{(ACCW-PW){w_prod[j][PW-1]}}, w_prod[j]};
         w_shift[j]     = r_acc[j] >>> FRAC;
         w_sum[j]       = {w_shift[j][ACCW-1], w_shift[j]}
                        + {{(ACCW+1-dataWidth){bias_in[j*dataWidth+dataWidth-1]}}, bias_in[j*dataWidth +: dataWidth]};
         if (actype == 1 && w_sum[j][ACCW]) begin
            w_res[j] = '0;
         end else if (w_sum[j] > SAT_MAX) begin
            w_res[j] = SAT_MAX[dataWidth-1:0];
         end else if (w_sum[j] < SAT_MIN) begin
            w_res[j] = SAT_MIN[dataWidth-1:0];
         end else begin
            w_res[j] = w_sum[j][dataWidth-1:0];
         end
      end
   end

   // Next-state: finish a frame on the last sample, spend one cycle finalising, then drain N_OUT results
   always_comb begin
      w_stateNext = r_state;
      unique case (r_state)
         ACCUM:   if (w_accept && w_lastIn) w_stateNext = FINAL;
         FINAL:   w_stateNext = DRAIN;
         DRAIN:   if (w_lastOut) w_stateNext = ACCUM;
         default: w_stateNext = ACCUM;
      endcase
   end

   // State register, frozen while the clock enable is low
   always_ff @(posedge clk) begin
      if (global_rst) begin
         r_state <= ACCUM;
      end else if (ce) begin
         r_state <= w_stateNext;
      end
   end

   // Accumulators and sample index; accumulators are wiped once the last result has been drained
   always_ff @(posedge clk) begin
      if (global_rst) begin
         for (int j = 0; j < N_OUT; j++) r_acc[j] <= '0;
         r_inIdx <= '0;
      end else if (w_accept) begin
         for (int j = 0; j < N_OUT; j++) r_acc[j] <= r_acc[j] + w_prodExt[j];
         r_inIdx <= w_lastIn ? '0 : r_inIdx + IW'(1);
      end else if (ce && r_state == DRAIN && w_lastOut) begin
         for (int j = 0; j < N_OUT; j++) r_acc[j] <= '0;
      end
   end

   // Result capture in FINAL and one-result-per-cycle output streaming in DRAIN
   always_ff @(posedge clk) begin
      if (global_rst) begin
         for (int j = 0; j < N_OUT; j++) r_res[j] <= '0;
         r_k        <= '0;
         r_dataOut  <= '0;
         r_classIdx <= '0;
         r_validOut <= 1'b0;
         r_endOut   <= 1'b0;
      end else if (ce) begin
         r_validOut <= 1'b0;
         r_endOut   <= 1'b0;
         if (r_state == FINAL) begin
            r_res <= w_res;
            r_k   <= '0;
         end else if (r_state == DRAIN) begin
            r_dataOut  <= r_res[r_k];
            r_classIdx <= r_k;
            r_validOut <= 1'b1;
            r_endOut   <= w_lastOut;
            r_k        <= w_lastOut ? '0 : r_k + KW'(1);
         end
      end
   end

   // Sticky flag for samples that arrive while the stage cannot take them
   always_ff @(posedge clk) begin
      if (global_rst) begin
         r_overrun <= 1'b0;
      end else if (ce && w_sample && r_state != ACCUM) begin
         r_overrun <= 1'b1;
      end
   end

endmodule

// File: doc/fc_stage.md
# fc_stage

Fully-connected classifier stage placed directly downstream of the conv/activation/max-pool `layer` block. It consumes the pooled pixel stream (`data_out`/`valid_op`/`end_op` of `layer`) one value per cycle and multiply-accumulates each value into `N_OUT` parallel neuron accumulators, using weights presented alongside the sample. After `N_IN` samples it adds bias, applies the activation, saturates, and streams the `N_OUT` results out, one per cycle.

## Interface
- `dataWidth`, 8: width of samples, weights, biases and outputs (signed two's complement).
- `N_IN`, 169: samples per frame (13x13 pooled map for W=28, K=3, P=2).
- `N_OUT`, 10: number of neurons.
- `FRAC`, 4: arithmetic right shift applied to the accumulator before the bias add.
- `actype`, 1: 1 => ReLU, 0 => linear (saturate only).

Ports:
- `clk`  in  1  single clock, all logic on rising edge.
- `global_rst`  in  1  synchronous, active-high reset.
- `ce`  in  1  clock enable; low freezes all state and registered outputs.
- `data_in`  in  dataWidth  pooled sample (from `layer.data_out`).
- `valid_in`  in  1  sample valid (from `layer.valid_op`).
- `end_in`  in  1  upstream end marker (from `layer.end_op`); `valid_in` is ignored while high.
- `weight_in`  in  N_OUT*dataWidth  weight for each neuron j in bits [j*dataWidth +: dataWidth], aligned with `data_in`.
- `bias_in`  in  N_OUT*dataWidth  bias per neuron, same packing; sampled in FINAL.
- `in_idx`  out  clog2(N_IN)  index of the next sample to be accepted (weight-memory address).
- `busy`  out  1  high in FINAL and DRAIN.
- `data_out`  out  dataWidth  neuron result.
- `class_idx`  out  clog2(N_OUT)  neuron index of `data_out`.
- `valid_out`  out  1  `data_out` valid.
- `end_out`  out  1  high with the last neuron of a frame.
- `overrun`  out  1  sticky: a sample arrived while busy.

## Operation
- States: ACCUM, FINAL, DRAIN. Reset state ACCUM.
- Accept = `ce & valid_in & ~end_in & (state==ACCUM)`.
- ACCUM: on accept, acc_j += data_in * w_j (signed 2*dataWidth product, accumulator width ACCW = 2*dataWidth + clog2(N_IN), sign-extended); `in_idx` increments. Accepting sample index N_IN-1 wraps `in_idx` to 0 and moves to FINAL.
- FINAL (one cycle): r_j = (acc_j >>> FRAC) + sign-extended bias_j, computed at ACCW+1 bits; if `actype`=1 and r_j<0 then r_j=0; saturate to [-2^(dataWidth-1), 2^(dataWidth-1)-1]; store into result registers; out counter k=0; go to DRAIN.
- DRAIN: each enabled cycle registers data_out=res_k, class_idx=k, valid_out=1, end_out=(k==N_OUT-1), k++. On k==N_OUT-1: clear all accumulators, go to ACCUM.
- `valid_in & ~end_in` while in FINAL/DRAIN: sample dropped, not counted, `overrun` set (cleared only by reset).
- `global_rst`: state ACCUM, accumulators, in_idx, k, result registers cleared; all outputs 0. Takes priority over `ce`.

## Timing
- Reset values: data_out=0, class_idx=0, valid_out=0, end_out=0, busy=0, overrun=0, in_idx=0.
- Edge E0 accepts last sample -> busy=1 after E0. E1: FINAL computes. E2..E(N_OUT+1): valid_out high after each, neuron 0..N_OUT-1; end_out high after E(N_OUT+1), busy low after E(N_OUT+1). valid_out low after E(N_OUT+2) unless ce low.
- Latency last sample -> first result: 2 enabled cycles; frame turnaround N_OUT+1 cycles of busy.
- First sample accepted at edge E(N_OUT+2) or later belongs to the next frame.
- `ce` low: every register, including valid_out, holds its value; timeline stretches by stalled cycles.
- Reset mid-DRAIN: valid_out=0 after the reset edge; no end_out issued; partial frame discarded.

## Test plan
- Reset: assert global_rst 2 cycles with random inputs -> all outputs 0, in_idx=0, busy=0.
- N_IN=4, N_OUT=2, FRAC=0, actype=1: data 1,2,3,4, w0=1, w1=-1, bias 0 -> data_out 10 (class 0), then 0 (class 1, end_out=1); with actype=0 -> 10 then 0xF6.
- Saturation: N_IN=4, FRAC=0, data=127, w=127, bias=0 -> 127; w=-128, actype=0 -> 0x80.
- Shift and bias: FRAC=4, acc 40, bias 3 -> 5; acc -40, bias 0, actype=0 -> 0xFD (arithmetic shift gives -3).
- Overrun: valid_in pulse during DRAIN -> overrun=1, in_idx unchanged, next frame results identical to a clean run.
- Stall/reset: ce low 3 cycles mid-ACCUM -> results match the unstalled run; global_rst after the first DRAIN output -> valid_out 0 next cycle, next full frame correct.
